// File: rtl/pe_boundary_buffer.sv
// pe_boundary_buffer: target store, pass replay sequencer and boundary-column FIFO for the SW PE chain.
// Defining SCORE_POS_EN adds score_pos_o, the in-pass capture index of the last strict score increase.
`ifndef CALC_BIT
`define CALC_BIT 16
`endif

module pe_boundary_buffer #(
    parameter int CALC_BIT  = `CALC_BIT,
    parameter int DEPTH_BIT = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [CALC_BIT-1:0] alpha_i,
    input  logic                       load_start_i,
    input  logic [DEPTH_BIT:0]         t_len_i,
    input  logic                       tgt_valid_i,
    output logic                       tgt_ready_o,
    input  logic [1:0]                 tgt_base_i,
    input  logic                       pass_start_i,
    output logic [2:0]                 feed_t,
    output logic signed [CALC_BIT-1:0] feed_v,
    output logic signed [CALC_BIT-1:0] feed_v_a,
    output logic signed [CALC_BIT-1:0] feed_f_b,
    output logic [CALC_BIT-1:0]        feed_max,
    input  logic [2:0]                 cap_t,
    input  logic signed [CALC_BIT-1:0] cap_v,
    input  logic signed [CALC_BIT-1:0] cap_f_b,
    input  logic [CALC_BIT-1:0]        cap_max,
    output logic                       busy_o,
    output logic                       pass_done_o,
    output logic [CALC_BIT-1:0]        score_o,
    output logic                       overflow_o
`ifdef SCORE_POS_EN
    ,
    output logic [DEPTH_BIT-1:0]       score_pos_o
`endif
);

    localparam int DEPTH   = 1 << DEPTH_BIT;
    localparam int ENTRY_W = 2 + 2 * CALC_BIT;
    localparam logic [DEPTH_BIT:0] FULL_CNT = {1'b1, {DEPTH_BIT{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_WAIT} state_t;

    state_t                      state_q, state_d;
    logic [DEPTH_BIT-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BIT:0]          count_q, count_d, t_len_q, t_len_d, seq_cnt_q, seq_cnt_d;
    logic [CALC_BIT-1:0]         score_q, score_d, feed_max_q, feed_max_d;
    logic                        ovf_q, ovf_d, done_q, done_d, ready_q, ready_d, busy_q, busy_d;
    logic [2:0]                  feed_t_q, feed_t_d;
    logic signed [CALC_BIT-1:0]  feed_v_q, feed_v_d, feed_va_q, feed_va_d, feed_fb_q, feed_fb_d;

    logic [ENTRY_W-1:0]          mem [0:DEPTH-1];
    logic [ENTRY_W-1:0]          rd_entry, mem_wdata;
    logic                        mem_we, wr, rd, pass_go, cap_hit, cap_end;
    logic signed [CALC_BIT-1:0]  rd_v, rd_fb;

`ifdef SCORE_POS_EN
    logic [DEPTH_BIT-1:0]        pos_q, pos_d, cidx_q, cidx_d;
`endif

    assign rd_entry = mem[rd_ptr_q];
    assign rd_v     = rd_entry[2*CALC_BIT-1:CALC_BIT];
    assign rd_fb    = rd_entry[CALC_BIT-1:0];
    assign cap_hit  = cap_t[2];
    assign cap_end  = (cap_t == 3'b001);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        t_len_d    = t_len_q;
        seq_cnt_d  = seq_cnt_q;
        score_d    = score_q;
        ovf_d      = ovf_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        feed_t_d   = 3'b000;
        feed_v_d   = '0;
        feed_va_d  = '0;
        feed_fb_d  = '0;
        feed_max_d = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        wr         = 1'b0;
        rd         = 1'b0;
        pass_go    = 1'b0;
`ifdef SCORE_POS_EN
        pos_d      = pos_q;
        cidx_d     = cidx_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pass_start_i && (count_q == t_len_q)) begin
                    pass_go   = 1'b1;
                    state_d   = S_FEED;
                    seq_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (tgt_valid_i && ready_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = {tgt_base_i, {CALC_BIT{1'b0}}, alpha_i};
                    wr        = 1'b1;
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
                ready_d = (seq_cnt_d < t_len_q);
                if (seq_cnt_d >= t_len_q) begin
                    state_d = S_IDLE;
                end
            end
            S_FEED: begin
                if (seq_cnt_q < t_len_q) begin
                    rd         = 1'b1;
                    feed_t_d   = {1'b1, rd_entry[ENTRY_W-1 -: 2]};
                    feed_v_d   = rd_v;
                    feed_va_d  = rd_v + alpha_i;
                    feed_fb_d  = rd_fb;
                    feed_max_d = score_q;
                    seq_cnt_d  = seq_cnt_q + 1'b1;
                end else begin
                    feed_t_d = 3'b001;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cap_end) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Boundary capture and score reduction run alongside replay, but never while loading.
        if (state_q != S_LOAD) begin
            if (cap_hit) begin
                if (count_q == FULL_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = {cap_t[1:0], cap_v, cap_f_b};
                    wr        = 1'b1;
                end
            end
            if ((cap_hit || cap_end) && (cap_max > score_q)) begin
                score_d = cap_max;
`ifdef SCORE_POS_EN
                pos_d   = cidx_q;
`endif
            end
`ifdef SCORE_POS_EN
            if (cap_hit) begin
                cidx_d = cidx_q + 1'b1;
            end
`endif
        end

`ifdef SCORE_POS_EN
        if (pass_go) begin
            pos_d  = '0;
            cidx_d = '0;
        end
`endif

        if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr && !rd) count_d = count_q + 1'b1;
        else if (rd && !wr) count_d = count_q - 1'b1;

        if (load_start_i) begin
            state_d    = S_LOAD;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            score_d    = '0;
            ovf_d      = 1'b0;
            t_len_d    = t_len_i;
            seq_cnt_d  = '0;
            ready_d    = (t_len_i != '0);
            done_d     = 1'b0;
            feed_t_d   = 3'b000;
            feed_v_d   = '0;
            feed_va_d  = '0;
            feed_fb_d  = '0;
            feed_max_d = '0;
            mem_we     = 1'b0;
`ifdef SCORE_POS_EN
            pos_d      = '0;
            cidx_d     = '0;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            t_len_q    <= '0;
            seq_cnt_q  <= '0;
            score_q    <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            feed_t_q   <= 3'b000;
            feed_v_q   <= '0;
            feed_va_q  <= '0;
            feed_fb_q  <= '0;
            feed_max_q <= '0;
`ifdef SCORE_POS_EN
            pos_q      <= '0;
            cidx_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            t_len_q    <= t_len_d;
            seq_cnt_q  <= seq_cnt_d;
            score_q    <= score_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            feed_t_q   <= feed_t_d;
            feed_v_q   <= feed_v_d;
            feed_va_q  <= feed_va_d;
            feed_fb_q  <= feed_fb_d;
            feed_max_q <= feed_max_d;
`ifdef SCORE_POS_EN
            pos_q      <= pos_d;
            cidx_q     <= cidx_d;
`endif
        end
    end

    assign tgt_ready_o = ready_q;
    assign feed_t      = feed_t_q;
    assign feed_v      = feed_v_q;
    assign feed_v_a    = feed_va_q;
    assign feed_f_b    = feed_fb_q;
    assign feed_max    = feed_max_q;
    assign busy_o      = busy_q;
    assign pass_done_o = done_q;
    assign score_o     = score_q;
    assign overflow_o  = ovf_q;
`ifdef SCORE_POS_EN
    assign score_pos_o = pos_q;
`endif

endmodule

// File: tb/tb_pe_boundary_buffer.sv
// Directed bench for pe_boundary_buffer: load, replay with a 3-cycle PE loopback, overflow, abort and reset.
`timescale 1ns/1ps

module tb_pe_boundary_buffer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] alpha_i = -16'sd3;
    logic               load_start_i = 1'b0;
    logic [3:0]         t_len_i = '0;
    logic               tgt_valid_i = 1'b0;
    logic               tgt_ready_o;
    logic [1:0]         tgt_base_i = '0;
    logic               pass_start_i = 1'b0;
    logic [2:0]         feed_t;
    logic signed [15:0] feed_v, feed_v_a, feed_f_b;
    logic [15:0]        feed_max;
    logic [2:0]         cap_t;
    logic signed [15:0] cap_v, cap_f_b;
    logic [15:0]        cap_max;
    logic               busy_o, pass_done_o, overflow_o;
    logic [15:0]        score_o;
`ifdef SCORE_POS_EN
    logic [2:0]         score_pos_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // PE chain stand-in: 3-cycle loopback of feed_t/feed_f_b, v and max taken from tables.
    logic               loop_en = 1'b0;
    logic [2:0]         drv_cap_t = '0;
    logic signed [15:0] drv_cap_v = '0;
    logic [15:0]        drv_cap_max = '0;
    logic [2:0]         d1_t = '0, d2_t = '0, d3_t = '0;
    logic signed [15:0] d1_fb = '0, d2_fb = '0, d3_fb = '0;
    logic [1:0]         cap_idx = '0;
    logic signed [15:0] vtab [4] = '{16'sd5, 16'sd7, 16'sd2, 16'sd9};
    logic [15:0]        mtab [4] = '{16'd3, 16'd5, 16'd7, 16'd9};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1_t  <= feed_t;
        d2_t  <= d1_t;
        d3_t  <= d2_t;
        d1_fb <= feed_f_b;
        d2_fb <= d1_fb;
        d3_fb <= d2_fb;
        if (loop_en && d3_t[2]) cap_idx <= cap_idx + 2'd1;
    end

    assign cap_t   = loop_en ? d3_t : drv_cap_t;
    assign cap_v   = loop_en ? vtab[cap_idx] : drv_cap_v;
    assign cap_f_b = loop_en ? d3_fb : 16'sd0;
    assign cap_max = loop_en ? (d3_t[2] ? mtab[cap_idx] : ((d3_t == 3'b001) ? 16'd9 : 16'd0)) : drv_cap_max;

    pe_boundary_buffer #(.CALC_BIT(16), .DEPTH_BIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .alpha_i(alpha_i), .load_start_i(load_start_i), .t_len_i(t_len_i),
        .tgt_valid_i(tgt_valid_i), .tgt_ready_o(tgt_ready_o), .tgt_base_i(tgt_base_i),
        .pass_start_i(pass_start_i), .feed_t(feed_t), .feed_v(feed_v), .feed_v_a(feed_v_a),
        .feed_f_b(feed_f_b), .feed_max(feed_max), .cap_t(cap_t), .cap_v(cap_v), .cap_f_b(cap_f_b),
        .cap_max(cap_max), .busy_o(busy_o), .pass_done_o(pass_done_o), .score_o(score_o),
        .overflow_o(overflow_o)
`ifdef SCORE_POS_EN
        , .score_pos_o(score_pos_o)
`endif
    );

    task automatic do_load(input int len);
        load_start_i = 1'b1;
        t_len_i      = 4'(len);
        @(negedge clk);
        load_start_i = 1'b0;
        for (int i = 0; i < len; i++) begin
            tgt_valid_i = 1'b1;
            tgt_base_i  = 2'(i);
            @(negedge clk);
        end
        tgt_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (feed_t !== 3'b000) begin n_fail++; $display("FAIL reset_feed_t got %b want 000", feed_t); end
        n_checks++; if (tgt_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", tgt_ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (pass_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", pass_done_o); end
        n_checks++; if (score_o !== 16'd0) begin n_fail++; $display("FAIL reset_score got %0d want 0", score_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        load_start_i = 1'b1;
        t_len_i      = 4'd4;
        @(negedge clk);
        load_start_i = 1'b0;
        n_checks++; if (tgt_ready_o !== 1'b1) begin n_fail++; $display("FAIL load_ready got %b want 1", tgt_ready_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL load_busy got %b want 1", busy_o); end
        for (int i = 0; i < 4; i++) begin
            tgt_valid_i = 1'b1;
            tgt_base_i  = 2'(i);
            @(negedge clk);
        end
        tgt_valid_i = 1'b0;
        n_checks++; if (tgt_ready_o !== 1'b0) begin n_fail++; $display("FAIL load_ready_end got %b want 0", tgt_ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL load_busy_end got %b want 0", busy_o); end
    endtask

    task automatic test_pass(input bit second);
        logic [2:0]         et;
        logic signed [15:0] ev, eva, efb;
        int                 done_cnt;
        loop_en      = 1'b1;
        pass_start_i = 1'b1;
        @(negedge clk);
        pass_start_i = 1'b0;
        n_checks++; if (feed_t !== 3'b000) begin n_fail++; $display("FAIL pass%0d_lat got %b want 000", second, feed_t); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            et  = (i < 4) ? {1'b1, 2'(i)} : 3'b001;
            ev  = (i < 4 && second) ? vtab[i] : 16'sd0;
            efb = (i < 4) ? -16'sd3 : 16'sd0;
            if (!second) eva = (i < 4) ? -16'sd3 : 16'sd0;
            else eva = (i == 0) ? 16'sd2 : (i == 1) ? 16'sd4 : (i == 2) ? -16'sd1 : (i == 3) ? 16'sd6 : 16'sd0;
            n_checks++; if (feed_t !== et) begin n_fail++; $display("FAIL pass%0d_t[%0d] got %b want %b", second, i, feed_t, et); end
            n_checks++; if (feed_v !== ev) begin n_fail++; $display("FAIL pass%0d_v[%0d] got %0d want %0d", second, i, feed_v, ev); end
            n_checks++; if (feed_v_a !== eva) begin n_fail++; $display("FAIL pass%0d_va[%0d] got %0d want %0d", second, i, feed_v_a, eva); end
            n_checks++; if (feed_f_b !== efb) begin n_fail++; $display("FAIL pass%0d_fb[%0d] got %0d want %0d", second, i, feed_f_b, efb); end
            if (second && i == 0) begin
                n_checks++; if (feed_max !== 16'd9) begin n_fail++; $display("FAIL pass1_max got %0d want 9", feed_max); end
            end
        end
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (pass_done_o === 1'b1) done_cnt++;
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL pass%0d_done_pulses got %0d want 1", second, done_cnt); end
        n_checks++; if (score_o !== 16'd9) begin n_fail++; $display("FAIL pass%0d_score got %0d want 9", second, score_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL pass%0d_busy got %b want 0", second, busy_o); end
        loop_en = 1'b0;
    endtask

    task automatic test_ignore();
        load_start_i = 1'b1;
        t_len_i      = 4'd4;
        @(negedge clk);
        load_start_i = 1'b0;
        pass_start_i = 1'b1;
        @(negedge clk);
        pass_start_i = 1'b0;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ign_load_busy got %b want 1", busy_o); end
        n_checks++; if (tgt_ready_o !== 1'b1) begin n_fail++; $display("FAIL ign_load_ready got %b want 1", tgt_ready_o); end
        @(negedge clk);
        n_checks++; if (feed_t !== 3'b000) begin n_fail++; $display("FAIL ign_load_feed got %b want 000", feed_t); end
        for (int i = 0; i < 4; i++) begin
            tgt_valid_i = 1'b1;
            tgt_base_i  = 2'(i);
            @(negedge clk);
        end
        tgt_valid_i  = 1'b0;
        pass_start_i = 1'b1;
        @(negedge clk);
        pass_start_i = 1'b0;
        repeat (5) @(negedge clk);
        drv_cap_t = 3'b001;
        @(negedge clk);
        drv_cap_t = 3'b000;
        n_checks++; if (pass_done_o !== 1'b1) begin n_fail++; $display("FAIL ign_done got %b want 1", pass_done_o); end
        // No captures came back, so the FIFO is now empty and short of t_len.
        pass_start_i = 1'b1;
        @(negedge clk);
        pass_start_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ign_short_busy got %b want 0", busy_o); end
        @(negedge clk);
        n_checks++; if (feed_t !== 3'b000) begin n_fail++; $display("FAIL ign_short_feed got %b want 000", feed_t); end
    endtask

    task automatic test_abort();
        do_load(4);
        drv_cap_t   = 3'b001;
        drv_cap_max = 16'd20;
        @(negedge clk);
        drv_cap_t   = 3'b000;
        drv_cap_max = 16'd0;
        n_checks++; if (score_o !== 16'd20) begin n_fail++; $display("FAIL abort_score_pre got %0d want 20", score_o); end
        pass_start_i = 1'b1;
        @(negedge clk);
        pass_start_i = 1'b0;
        @(negedge clk);
        n_checks++; if (feed_t !== 3'b100) begin n_fail++; $display("FAIL abort_feed0 got %b want 100", feed_t); end
        n_checks++; if (feed_max !== 16'd20) begin n_fail++; $display("FAIL abort_max got %0d want 20", feed_max); end
        @(negedge clk);
        load_start_i = 1'b1;
        t_len_i      = 4'd4;
        @(negedge clk);
        load_start_i = 1'b0;
        n_checks++; if (feed_t !== 3'b000) begin n_fail++; $display("FAIL abort_feed got %b want 000", feed_t); end
        n_checks++; if (score_o !== 16'd0) begin n_fail++; $display("FAIL abort_score got %0d want 0", score_o); end
        n_checks++; if (tgt_ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", tgt_ready_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %b want 1", busy_o); end
    endtask

    task automatic test_async_reset();
        do_load(4);
        drv_cap_t   = 3'b001;
        drv_cap_max = 16'd20;
        @(negedge clk);
        drv_cap_t   = 3'b000;
        drv_cap_max = 16'd0;
        pass_start_i = 1'b1;
        @(negedge clk);
        pass_start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (feed_t !== 3'b000) begin n_fail++; $display("FAIL arst_feed_t got %b want 000", feed_t); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy_o); end
        n_checks++; if (score_o !== 16'd0) begin n_fail++; $display("FAIL arst_score got %0d want 0", score_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        do_load(8);
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b want 0", overflow_o); end
        drv_cap_t = 3'b111;
        drv_cap_v = 16'sd77;
        @(negedge clk);
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow_o); end
        repeat (2) @(negedge clk);
        drv_cap_t = 3'b000;
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
        pass_start_i = 1'b1;
        @(negedge clk);
        pass_start_i = 1'b0;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ovf_pass_busy got %b want 1", busy_o); end
        @(negedge clk);
        n_checks++; if (feed_t !== 3'b100) begin n_fail++; $display("FAIL ovf_feed0 got %b want 100", feed_t); end
        n_checks++; if (feed_v !== 16'sd0) begin n_fail++; $display("FAIL ovf_v0 got %0d want 0", feed_v); end
        @(negedge clk);
        n_checks++; if (feed_t !== 3'b101) begin n_fail++; $display("FAIL ovf_feed1 got %b want 101", feed_t); end
        load_start_i = 1'b1;
        t_len_i      = 4'd0;
        @(negedge clk);
        load_start_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow_o); end
        n_checks++; if (tgt_ready_o !== 1'b0) begin n_fail++; $display("FAIL zero_len_ready got %b want 0", tgt_ready_o); end
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL zero_len_idle got %b want 0", busy_o); end
    endtask

`ifdef SCORE_POS_EN
    task automatic test_score_pos();
        logic [15:0] mseq [4] = '{16'd3, 16'd8, 16'd8, 16'd5};
        do_load(4);
        pass_start_i = 1'b1;
        @(negedge clk);
        pass_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv_cap_t   = 3'b100;
            drv_cap_max = mseq[i];
            @(negedge clk);
        end
        drv_cap_t   = 3'b000;
        drv_cap_max = 16'd0;
        n_checks++; if (score_pos_o !== 3'd1) begin n_fail++; $display("FAIL score_pos got %0d want 1", score_pos_o); end
        n_checks++; if (score_o !== 16'd8) begin n_fail++; $display("FAIL score_pos_score got %0d want 8", score_o); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end want end");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_pass(1'b0);
        test_pass(1'b1);
        test_ignore();
        test_abort();
        test_async_reset();
        test_overflow();
`ifdef SCORE_POS_EN
        test_score_pos();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
